// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Classifies debounced push-button activity into short, long and double
// presses. Consumes the one-cycle press/release pulses of the upstream
// edge-detect stage and produces one-cycle event pulses plus a hold level.
//
// Parameters:
//   LONG_CYCLES  hold duration (clk cycles) that qualifies a long press
//   GAP_CYCLES   max release-to-press gap (clk cycles) for a double press
//   CNT_W        counter width, must hold max(LONG_CYCLES, GAP_CYCLES) - 1
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   press_pulse    one-cycle press event (posEdge_detect)
//   release_pulse  one-cycle release event (falEdge_detect)
//   short_press    one-cycle pulse: single press+release, no second press in time
//   long_press     one-cycle pulse: press held for LONG_CYCLES
//   double_press   one-cycle pulse: second press released within the gap window
//   held           level: high from long_press until the release
//   state_dbg      current FSM state encoding (debug observation only)
//
// Event pulses are plain one-cycle strobes with no back-pressure: the
// consumer must capture them in the cycle they are high.
// -----------------------------------------------------------------------------
module button_press_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_pulse,
  input  logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_PRESSED2  = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             short_n, long_n, double_n, held_n;
  logic             pr, rl;

  // A press and a release on the same edge cancel each other out; the
  // counter keeps running as if nothing had been sampled.
  assign pr = press_pulse & ~release_pulse;
  assign rl = release_pulse & ~press_pulse;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (pr) state_n = S_PRESSED1;
      end

      // Release is tested before the threshold so that a release landing on
      // the threshold edge still counts as a short/double gesture.
      S_PRESSED1: begin
        if (rl) begin
          state_n = S_WAIT_GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST) begin
          state_n = S_LONG_HELD;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      // Press wins over gap expiry on the same edge.
      S_WAIT_GAP: begin
        if (pr) begin
          state_n = S_PRESSED2;
          cnt_n   = '0;
        end else if (cnt == GAP_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      // A second press held past the threshold becomes a long press; the
      // first press is dropped and no double_press is reported.
      S_PRESSED2: begin
        if (rl) begin
          state_n  = S_IDLE;
          cnt_n    = '0;
          double_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = S_LONG_HELD;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      S_LONG_HELD: begin
        cnt_n = '0;
        if (rl) state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    held_n = (state_n == S_LONG_HELD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_press <= double_n;
      held         <= held_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies debounced push-button activity into short, long and double presses. Sits directly downstream of the push-button edge-detect stage and consumes its one-cycle `posEdge_detect` (press) and `falEdge_detect` (release) pulses. It emits one-cycle event pulses plus a hold level for the application logic.

## Interface
- `LONG_CYCLES`, 50_000_000: hold duration in `clk` cycles (500 ms at 100 MHz) that qualifies a long press.
- `GAP_CYCLES`, 25_000_000: maximum release-to-press gap in `clk` cycles for a double press.
- `CNT_W`, 26: counter width; must hold max(`LONG_CYCLES`, `GAP_CYCLES`) − 1.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `press_pulse`  in  1  one-cycle press event, driven from the edge-detect stage's `posEdge_detect`.
- `release_pulse`  in  1  one-cycle release event, driven from the edge-detect stage's `falEdge_detect`.
- `short_press`  out  1  one-cycle pulse: single press and release, no second press in time.
- `long_press`  out  1  one-cycle pulse: press held for `LONG_CYCLES`.
- `double_press`  out  1  one-cycle pulse: second press released within the gap window.
- `held`  out  1  level: high from `long_press` until the release.

## Operation
- States: IDLE, PRESSED1, WAIT_GAP, PRESSED2, LONG_HELD. `cnt` clears to 0 on every state entry and increments by 1 each cycle while in PRESSED1, WAIT_GAP or PRESSED2. `cnt` saturates and never wraps.
- IDLE:
  - press → PRESSED1.
  - release is ignored.
- PRESSED1:
  - release → WAIT_GAP.
  - `cnt` == `LONG_CYCLES`−1 with no release on that edge → LONG_HELD; pulse `long_press`; set `held`.
  - press is ignored.
- WAIT_GAP:
  - press → PRESSED2.
  - `cnt` == `GAP_CYCLES`−1 with no press on that edge → IDLE; pulse `short_press`.
  - release is ignored.
- PRESSED2:
  - release → IDLE; pulse `double_press`.
  - `cnt` == `LONG_CYCLES`−1 with no release on that edge → LONG_HELD; pulse `long_press`; set `held`. The first press is discarded and no `double_press` is issued.
- LONG_HELD:
  - release → IDLE; clear `held`.
  - press is ignored.
  - Remains in this state indefinitely until a release arrives.
- Simultaneous events:
  - Press and release sampled on the same edge: both are ignored and the counter continues.
  - A release on the same edge as the long threshold takes priority (release path).
  - A press on the same edge as the gap expiry takes priority (PRESSED2).
- Exactly one event output (`short_press`, `long_press` or `double_press`) fires per classified gesture. No two event outputs are ever high in the same cycle.

## Timing
- All outputs are registered. Each event pulse is high for exactly one cycle, starting in the cycle after the deciding edge.
- While `rst`=0: state = IDLE, `cnt` = 0, and `short_press`, `long_press`, `double_press`, `held` are all 0, asynchronously. Deassertion takes effect at the next rising `clk` edge.
- Let edge E0 sample the press. Long press: `long_press` and `held` rise after edge E0+`LONG_CYCLES`, provided no release was sampled on edges E0+1..E0+`LONG_CYCLES`.
- Let edge E1 sample the release in PRESSED1. Short press: `short_press` pulses after edge E1+`GAP_CYCLES`, provided no press was sampled on edges E1+1..E1+`GAP_CYCLES`.
- Double press: `double_press` pulses after the edge that samples the second release.
- `held` falls after the edge that samples the release in LONG_HELD.
- Reset asserted mid-gesture aborts it. No pending pulse is emitted after reset.
- Back-to-back gestures are supported: a press sampled on the edge immediately after a return to IDLE is accepted.

## Test plan
All scenarios use `LONG_CYCLES`=20, `GAP_CYCLES`=10, `CNT_W`=5 and a 10 ns clock. Edge numbers are relative to the first press.
- Reset: hold `rst`=0 with pulses toggling → all outputs 0. Release `rst` → no output activity until a press arrives.
- Short press: press@0, release@5 → `short_press`=1 for one cycle after edge 15; `long_press`, `double_press` and `held` stay 0.
- Long press: press@0, no release until edge 40 → `long_press` pulses after edge 20; `held`=1 from after edge 20 until after edge 40; no `short_press`.
- Double press: press@0, release@5, press@12, release@16 → `double_press` pulses after edge 16; no `short_press`.
- Boundaries:
  - press@0, release@20 → no `long_press`; `short_press` after edge 30.
  - press@0, release@5, press@15 → PRESSED2; release@18 → `double_press` after edge 18.
- Reset mid-hold: press@0, `rst`=0 at edge 10 for 3 cycles, release@30 → no event pulses and `held`=0 throughout.
